// File: rtl/noc_router_np.sv
// -----------------------------------------------------------------------------
// noc_router_np
// Parametrised N-port router. Each input channel owns a first-word-fall-through
// FIFO. The head flit of each FIFO requests the output named in its header. Each
// output picks one requester with its own rotate-after-grant round-robin
// pointer. Malformed heads are popped without being forwarded, and they are
// counted in a saturating counter.
//
// Flit format: bit 0 = valid, bits [DW:1] = destination output index.
//
// Ports
//   clk              clock
//   reset            asynchronous, active-high reset
//   in_write         per-channel write strobe into the input FIFO
//   in_data          input flits, channel i at [i*WIDTH +: WIDTH]
//   in_full          input FIFO i holds DEPTH entries
//   in_almost_full   input FIFO i holds >= DEPTH-1 entries
//   out_write        registered write strobe to the downstream FIFO
//   out_data         registered output flits, same packing as in_data
//   out_full         downstream FIFO full
//   out_almost_full  downstream FIFO holds >= its depth-1 entries
//   drop_count       saturating count of discarded malformed flits
// -----------------------------------------------------------------------------
module noc_router_np #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 32,
  parameter int NPORTS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        in_write,
  input  logic [NPORTS*WIDTH-1:0]  in_data,
  output logic [NPORTS-1:0]        in_full,
  output logic [NPORTS-1:0]        in_almost_full,
  output logic [NPORTS-1:0]        out_write,
  output logic [NPORTS*WIDTH-1:0]  out_data,
  input  logic [NPORTS-1:0]        out_full,
  input  logic [NPORTS-1:0]        out_almost_full,
  output logic [15:0]              drop_count
);

  localparam int DW = ($clog2(NPORTS) > 1) ? $clog2(NPORTS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Port count widened by one bit so that an out-of-range destination can be
  // detected when NPORTS is not a power of two.
  localparam logic [DW:0] NP_L = (DW+1)'(NPORTS);

  // Input FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem    [NPORTS][DEPTH];
  logic [AW-1:0]    wr_ptr [NPORTS];
  logic [AW-1:0]    rd_ptr [NPORTS];
  logic [CW-1:0]    count  [NPORTS];

  logic [WIDTH-1:0] head   [NPORTS];
  logic [DW-1:0]    dest   [NPORTS];
  logic [NPORTS-1:0] push, pop, req_ok, drop, grant_in;

  // Arbitration results
  logic [NPORTS-1:0] eligible, gnt_valid;
  logic [DW-1:0]     gnt_idx [NPORTS];
  logic [DW-1:0]     rr      [NPORTS];

  logic [4:0]  drop_inc;
  logic [16:0] drop_sum;

  // Head decode, FIFO status and request generation.
  // Full is taken from the registered count, so a push is refused on a full
  // FIFO even if the same cycle pops it.
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      head[i]           = mem[i][rd_ptr[i]];
      dest[i]           = head[i][DW:1];
      in_full[i]        = (count[i] == CW'(DEPTH));
      in_almost_full[i] = (count[i] >= CW'(DEPTH - 1));
      push[i]           = in_write[i] & ~in_full[i];
      req_ok[i]         = (count[i] != '0) & head[i][0] & ({1'b0, dest[i]} < NP_L);
      drop[i]           = (count[i] != '0) & ~req_ok[i];
    end
  end

  // An output that just wrote into an almost-full downstream FIFO must skip a
  // cycle, because that write may have filled it.
  assign eligible = ~out_full & ~(out_almost_full & out_write);

  // Per-output round-robin. The scan starts at rr[p] and wraps. Each input has
  // only one destination, so it cannot be granted by two outputs at once.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    gnt_valid = '0;
    grant_in  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      gnt_idx[p] = '0;
      for (int k = 0; k < NPORTS; k++) begin
        // NOTE: blocking assignments inside combinational logic, because idx is
        // a temporary that must be read back in the same pass.
        idx = int'(rr[p]) + k;
        if (idx >= NPORTS) idx = idx - NPORTS;
        if (!gnt_valid[p] && eligible[p] && req_ok[idx] && dest[idx] == DW'(p)) begin
          gnt_valid[p]  = 1'b1;
          gnt_idx[p]    = DW'(idx);
          grant_in[idx] = 1'b1;
        end
      end
    end
  end

  assign pop = drop | grant_in;

  // Several inputs can drop in the same cycle, so the counter adds the number
  // of drops and clamps at all-ones.
  always_comb begin
    drop_inc = '0;
    for (int i = 0; i < NPORTS; i++) drop_inc = drop_inc + 5'(drop[i]);
    drop_sum = {1'b0, drop_count} + 17'(drop_inc);
  end

  // NOTE: the FIFO storage has no reset. Only the pointers and counts define
  // which entries are valid, so clearing the array would add reset fan-out for
  // no benefit.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Output registers, round-robin pointers and the drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_write  <= '0;
      out_data   <= '0;
      drop_count <= '0;
      for (int p = 0; p < NPORTS; p++) rr[p] <= '0;
    end else begin
      out_write  <= gnt_valid;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int p = 0; p < NPORTS; p++) begin
        if (gnt_valid[p]) begin
          out_data[p*WIDTH +: WIDTH] <= head[gnt_idx[p]];
          if (int'(gnt_idx[p]) == NPORTS - 1) rr[p] <= '0;
          else                                 rr[p] <= gnt_idx[p] + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_router_np.sv
// -----------------------------------------------------------------------------
// tb_noc_router_np
// Directed bench for noc_router_np. The main instance has 4 ports and depth 4.
// A second instance has 3 ports, so that a destination equal to 3 is out of
// range. Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at that same point.
// -----------------------------------------------------------------------------
module tb_noc_router_np;

  logic        clk = 1'b0;
  logic        reset;

  // 4-port instance
  logic [3:0]  in_write, in_full, in_almost_full;
  logic [63:0] in_data;
  logic [3:0]  out_write, out_full, out_almost_full;
  logic [63:0] out_data;
  logic [15:0] drop_count;

  // 3-port instance
  logic [2:0]  in_write3, in_full3, in_almost_full3;
  logic [47:0] in_data3;
  logic [2:0]  out_write3, out_full3, out_almost_full3;
  logic [47:0] out_data3;
  logic [15:0] drop_count3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  noc_router_np #(.WIDTH(16), .DEPTH(4), .NPORTS(4)) dut (
    .clk(clk), .reset(reset),
    .in_write(in_write), .in_data(in_data),
    .in_full(in_full), .in_almost_full(in_almost_full),
    .out_write(out_write), .out_data(out_data),
    .out_full(out_full), .out_almost_full(out_almost_full),
    .drop_count(drop_count)
  );

  noc_router_np #(.WIDTH(16), .DEPTH(4), .NPORTS(3)) dut3 (
    .clk(clk), .reset(reset),
    .in_write(in_write3), .in_data(in_data3),
    .in_full(in_full3), .in_almost_full(in_almost_full3),
    .out_write(out_write3), .out_data(out_data3),
    .out_full(out_full3), .out_almost_full(out_almost_full3),
    .drop_count(drop_count3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant order on output 1 when inputs 0, 1 and 3 compete
  int order [3] = '{0, 1, 3};

  initial begin
    reset = 1'b1;
    in_write = '0; in_data = '0; out_full = '0; out_almost_full = '0;
    in_write3 = '0; in_data3 = '0; out_full3 = '0; out_almost_full3 = '0;
    #12;
    check("rst_out_write", out_write, 4'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_in_full", {in_full, in_almost_full}, 8'h00);
    check("rst_drop", drop_count, 16'h0);
    reset = 1'b0;
    tick();

    // 1: single flit, 2-cycle latency, port 0 -> output 2
    in_write = 4'b0001; in_data[15:0] = 16'h0005;
    tick();
    in_write = '0;
    check("t1_not_yet", out_write, 4'b0000);
    tick();
    check("t1_write", out_write, 4'b0100);
    check("t1_data", out_data[47:32], 16'h0005);
    tick();
    check("t1_pulse_end", out_write, 4'b0000);
    check("t1_data_hold", out_data[47:32], 16'h0005);

    // 2: inputs 0, 1 and 3 each hold 3 flits for output 1. They are loaded
    //    under out_full, then released.
    out_full[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_write = 4'b1011;
      in_data[15:0]  = {4'h0, 4'(k), 8'h03};
      in_data[31:16] = {4'h1, 4'(k), 8'h03};
      in_data[63:48] = {4'h3, 4'(k), 8'h03};
      tick();
    end
    in_write = '0;
    out_full[1] = 1'b0;
    check("t2_held", out_write, 4'b0000);
    check("t2_almost_full", {in_full, in_almost_full}, {4'b0000, 4'b1011});
    for (int j = 0; j < 9; j++) begin
      tick();
      check($sformatf("t2_write_%0d", j), out_write, 4'b0010);
      check($sformatf("t2_data_%0d", j), out_data[31:16],
            {4'(order[j % 3]), 4'(j / 3), 8'h03});
    end
    tick();
    check("t2_done", out_write, 4'b0000);

    // 3a: out_almost_full with a write just issued blocks the next grant
    out_almost_full[0] = 1'b1;
    in_write = 4'b0010; in_data[31:16] = 16'h0101;
    tick();
    in_data[31:16] = 16'h0201;
    tick();
    in_write = '0;
    check("t3a_first", out_write, 4'b0001);
    check("t3a_first_data", out_data[15:0], 16'h0101);
    tick();
    check("t3a_blocked", out_write, 4'b0000);
    tick();
    check("t3a_second", out_write, 4'b0001);
    check("t3a_second_data", out_data[15:0], 16'h0201);
    out_almost_full[0] = 1'b0;
    tick();
    check("t3a_end", out_write, 4'b0000);

    // 3b: out_full on output 0 while input 2 fills up. The 5th write is refused.
    out_full[0] = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      in_write = 4'b0100; in_data[47:32] = {4'h0, 4'(n), 8'h01};
      tick();
      check($sformatf("t3b_nowrite_%0d", n), out_write, 4'b0000);
      if (n == 2) check("t3b_af_2", {in_full[2], in_almost_full[2]}, 2'b00);
      if (n == 3) check("t3b_af_3", {in_full[2], in_almost_full[2]}, 2'b01);
      if (n == 5) check("t3b_full_5", {in_full[2], in_almost_full[2]}, 2'b11);
    end
    in_write = '0;
    out_full[0] = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check($sformatf("t3b_drain_%0d", n), out_write, 4'b0001);
      check($sformatf("t3b_data_%0d", n), out_data[15:0], {4'h0, 4'(n), 8'h01});
    end
    tick();
    check("t3b_no_fifth", out_write, 4'b0000);
    check("t3b_empty", {in_full, in_almost_full}, 8'h00);

    // 5: four non-conflicting transfers in parallel
    in_write = 4'b1111;
    in_data = {16'hD005, 16'hC007, 16'hB001, 16'hA003};
    tick();
    in_write = '0;
    check("t5_not_yet", out_write, 4'b0000);
    tick();
    check("t5_write", out_write, 4'b1111);
    check("t5_data", out_data, 64'hC007_D005_A003_B001);
    tick();
    check("t5_end", out_write, 4'b0000);
    check("t5_no_drop", drop_count, 16'h0);

    // 4: malformed flits on the 3-port instance
    in_write3 = 3'b100; in_data3[47:32] = 16'h0004;
    tick();
    in_data3[47:32] = 16'h0007;
    tick();
    in_write3 = '0;
    check("t4_drop_1", drop_count3, 16'd1);
    check("t4_nowrite_1", out_write3, 3'b000);
    tick();
    check("t4_drop_2", drop_count3, 16'd2);
    check("t4_nowrite_2", out_write3, 3'b000);
    tick();
    check("t4_drop_hold", drop_count3, 16'd2);
    check("t4_nowrite_3", out_write3, 3'b000);

    // 4: saturation. All four inputs stream invalid flits, four drops per cycle.
    in_write = 4'b1111; in_data = '0;
    repeat (10) tick();
    check("t4_sat_partial", drop_count, 16'd36);
    repeat (16400) tick();
    check("t4_sat", drop_count, 16'hFFFF);
    check("t4_sat_nowrite", out_write, 4'b0000);
    in_write = '0;
    repeat (3) tick();
    check("t4_sat_hold", drop_count, 16'hFFFF);

    // 6: asynchronous reset in the middle of a burst
    in_write = 4'b0001; in_data[15:0] = 16'h0005;
    repeat (3) tick();
    check("t6_burst_active", out_write, 4'b0100);
    in_write = '0;
    #2 reset = 1'b1;
    #1;
    check("t6_rst_write", out_write, 4'b0000);
    check("t6_rst_data", out_data, 64'h0);
    check("t6_rst_drop", drop_count, 16'h0);
    check("t6_rst_full", {in_full, in_almost_full}, 8'h00);
    #1 reset = 1'b0;
    tick();
    check("t6_idle", out_write, 4'b0000);
    in_write = 4'b0001; in_data[15:0] = 16'h1205;
    tick();
    in_write = '0;
    check("t6_not_yet", out_write, 4'b0000);
    tick();
    check("t6_write", out_write, 4'b0100);
    check("t6_data", out_data[47:32], 16'h1205);
    tick();
    check("t6_end", out_write, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_router_np.md
# noc_router_np

Parametrised N-port mesh/ring router: each of NPORTS input channels owns a FIFO, head flits are switched to the output named in their header, and each output resolves contention with its own round-robin pointer. It sits between the PE network interfaces and neighbouring routers. It generalises the fixed 4-port router in three ways:
- port count, width and depth are parameters;
- arbitration is per-output rotate-after-grant;
- malformed flits are discarded and counted.

## Interface
- WIDTH, 16, flit width in bits (must be ≥ DW+1).
- DEPTH, 32, entries per input FIFO (power of two, ≥ 4).
- NPORTS, 4, number of input and output channels (2..8).
- Derived: DW = max(1, $clog2(NPORTS)); AW = $clog2(DEPTH).
- Flit format: bit 0 = valid; bits [DW:1] = destination output index.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- in_write  in  NPORTS  per-channel write strobe into input FIFO.
- in_data  in  NPORTS*WIDTH  input flits; channel i occupies [i*WIDTH +: WIDTH].
- in_full  out  NPORTS  input FIFO i holds DEPTH entries.
- in_almost_full  out  NPORTS  input FIFO i holds ≥ DEPTH-1 entries.
- out_write  out  NPORTS  registered write strobe to the downstream FIFO.
- out_data  out  NPORTS*WIDTH  registered output flits, same packing as in_data.
- out_full  in  NPORTS  downstream FIFO full.
- out_almost_full  in  NPORTS  downstream FIFO holds ≥ its depth-1 entries.
- drop_count  out  16  saturating count of discarded malformed flits.

## Operation
**Input FIFOs**
- One per channel, first-word-fall-through: the head is visible the cycle after it is written.
- in_write while in_full=1: flit discarded, FIFO unchanged, drop_count unchanged.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, the push is still refused (full is evaluated before the pop).
- Simultaneous push and pop on a non-full FIFO: count unchanged, both pointers advance modulo DEPTH.

**Request generation**
- Input i requests output d = head[DW:1] when its FIFO is non-empty, head[0]=1 and d < NPORTS.
- Malformed head (valid bit 0, or d ≥ NPORTS): popped that cycle without output; drop_count += 1, saturating at 16'hFFFF.

**Output eligibility** (per output p, this cycle)
- eligible[p] = ~out_full[p] & ~(out_almost_full[p] & out_write[p]).

**Arbitration** (per output p)
- Candidates are requesters for p, scanned cyclically starting at rr[p].
- If eligible[p], the first candidate found is granted: its head is popped, loaded into out_data[p], and out_write[p] is set for the next cycle.
- On a grant, rr[p] ← (granted+1) mod NPORTS; otherwise rr[p] holds.
- Each input names exactly one output, so at most one grant per input per cycle; all outputs arbitrate in parallel. U-turn (d = i) is legal.
- Ungranted heads stay in their FIFO. There is no retain register: the FIFO is the hold buffer.

**Output register**
- out_write[p] = 1 for exactly one cycle per granted flit; otherwise 0.
- out_data[p] is updated only on a grant and holds its value otherwise.

**Reset** (asynchronous, any cycle)
- FIFO pointers and counts = 0, so in_full = 0 and in_almost_full = 0.
- rr[*] = 0, out_write = 0, out_data = 0, drop_count = 0.
- A flit in flight is lost.

## Timing
- Minimum latency: in_write at edge t → out_write high in the cycle after edge t+1 (2 cycles), provided the target is eligible and uncontended.
- Throughput: one flit per output per cycle; sustained by one input to one output when out_full and out_almost_full stay low.
- in_full and in_almost_full are registered and reflect count after the edge.
- Backpressure: out_full and out_almost_full are sampled combinationally in the grant cycle. The downstream FIFO never receives a write while full, given its almost_full = depth-1 threshold.
- No combinational path from any input to any output.

## Test plan
1. NPORTS=4, DEPTH=4. One flit 16'h0005 (dst 2) into port 0 at cycle 1 → out_write[2]=1 with out_data[2]=16'h0005 at cycle 3; all other out_write stay 0.
2. Ports 0, 1 and 3 each hold 3 flits for dst 1 with no backpressure → output 1 grant order 0,1,3,0,1,3,0,1,3; 9 consecutive out_write[1] cycles.
3. Hold out_almost_full[0]=1 with out_write[0]=1 → no grant on output 0 next cycle. Hold out_full[0]=1 for 5 cycles → out_write[0]=0 throughout, head stays queued, in_full[i] asserts after 4 writes; the 5th write is discarded.
4. Malformed flits: 16'h0004 (valid=0) into port 2, then a flit with dst 3 under NPORTS=3 → both popped, no out_write, drop_count=2. With drop_count preloaded by 65535 drops → stays 16'hFFFF.
5. Parallel non-conflicting traffic: 0→1, 1→0, 2→3, 3→2 simultaneously → four out_write pulses in the same cycle.
6. Reset asserted mid-burst, between clock edges → outputs zero immediately; after release, in_full=0, drop_count=0, and the first new flit follows the 2-cycle latency.
